// File: rtl/lidar_frame_processor.sv
// LiDAR frame processor: hunts for the frame header, scans the distance samples
// for max/min angle, validates the XOR checksum and launches the result to the
// UART transmitter via the flashin / tx_busy handshake.
module lidar_frame_processor #(
    parameter int unsigned NUM_SAMPLES  = 8,
    parameter logic [15:0] ALERT_THRESH = 16'd500,
    parameter int unsigned FLASH_CYCLES = 4,
    parameter int unsigned BUSY_TIMEOUT = 8,
    parameter logic [15:0] HEADER       = 16'h55AA
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
    input  logic        tx_busy,
    output logic [15:0] lidar_header,
    output logic [47:0] data,
    output logic        flashin,
    output logic        frame_err,
    output logic        tx_timeout,
    output logic        busy
);

    typedef enum logic [2:0] {
        StHunt0,
        StHunt1,
        StSampHi,
        StSampLo,
        StCheck,
        StLaunch,
        StWaitBusy,
        StWaitDone
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  chk_q, chk_d;
    logic [7:0]  hi_q, hi_d;
    logic [15:0] max_q, max_d;
    logic [15:0] min_q, min_d;
    logic [7:0]  max_ang_q, max_ang_d;
    logic [7:0]  min_ang_q, min_ang_d;
    logic [15:0] cnt_q, cnt_d;
    logic [47:0] data_q, data_d;
    logic        flash_q, flash_d;
    logic        err_q, err_d;
    logic        tmo_q, tmo_d;

    logic [15:0] sample;
    assign sample = {hi_q, rx_byte};

    // Next-state and datapath decode; every register holds unless a rule fires.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        chk_d     = chk_q;
        hi_d      = hi_q;
        max_d     = max_q;
        min_d     = min_q;
        max_ang_d = max_ang_q;
        min_ang_d = min_ang_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        flash_d   = flash_q;
        err_d     = 1'b0;
        tmo_d     = 1'b0;
        case (state_q)
            StHunt0: begin
                if (rx_valid && rx_byte == HEADER[15:8]) state_d = StHunt1;
            end
            StHunt1: begin
                if (rx_valid) begin
                    if (rx_byte == HEADER[7:0]) begin
                        state_d   = StSampHi;
                        idx_d     = 8'd0;
                        chk_d     = 8'd0;
                        max_d     = 16'h0000;
                        min_d     = 16'hFFFF;
                        max_ang_d = 8'd0;
                        min_ang_d = 8'd0;
                    end else if (rx_byte != HEADER[15:8]) begin
                        // A repeated first header byte keeps us aligned.
                        state_d = StHunt0;
                    end
                end
            end
            StSampHi: begin
                if (rx_valid) begin
                    hi_d    = rx_byte;
                    chk_d   = chk_q ^ rx_byte;
                    state_d = StSampLo;
                end
            end
            StSampLo: begin
                if (rx_valid) begin
                    chk_d = chk_q ^ rx_byte;
                    // Strict compares so ties keep the lowest index.
                    if (sample > max_q) begin
                        max_d     = sample;
                        max_ang_d = idx_q;
                    end
                    if (sample < min_q) begin
                        min_d     = sample;
                        min_ang_d = idx_q;
                    end
                    if (idx_q == 8'(NUM_SAMPLES - 1)) begin
                        state_d = StCheck;
                    end else begin
                        idx_d   = idx_q + 8'd1;
                        state_d = StSampHi;
                    end
                end
            end
            StCheck: begin
                if (rx_valid) begin
                    if (rx_byte == chk_q) begin
                        data_d  = {8'h00, max_ang_q, 8'h00, min_ang_q,
                                   15'h0000, (min_q < ALERT_THRESH)};
                        cnt_d   = 16'd0;
                        state_d = StLaunch;
                    end else begin
                        err_d   = 1'b1;
                        state_d = StHunt0;
                    end
                end
            end
            StLaunch: begin
                // Once started, the flashin burst runs to completion regardless of tx_busy.
                if (flash_q) begin
                    if (cnt_q == 16'(FLASH_CYCLES)) begin
                        flash_d = 1'b0;
                        cnt_d   = 16'd0;
                        state_d = StWaitBusy;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end else if (!tx_busy) begin
                    flash_d = 1'b1;
                    cnt_d   = 16'd1;
                end
            end
            StWaitBusy: begin
                if (tx_busy) begin
                    state_d = StWaitDone;
                end else if (cnt_q == 16'(BUSY_TIMEOUT - 1)) begin
                    tmo_d   = 1'b1;
                    state_d = StHunt0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StWaitDone: begin
                if (!tx_busy) state_d = StHunt0;
            end
            default: state_d = StHunt0;
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) state_q <= StHunt0;
        else       state_q <= state_d;
    end

    // Datapath and registered output flops with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            idx_q     <= 8'd0;
            chk_q     <= 8'd0;
            hi_q      <= 8'd0;
            max_q     <= 16'd0;
            min_q     <= 16'd0;
            max_ang_q <= 8'd0;
            min_ang_q <= 8'd0;
            cnt_q     <= 16'd0;
            data_q    <= 48'd0;
            flash_q   <= 1'b0;
            err_q     <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            idx_q     <= idx_d;
            chk_q     <= chk_d;
            hi_q      <= hi_d;
            max_q     <= max_d;
            min_q     <= min_d;
            max_ang_q <= max_ang_d;
            min_ang_q <= min_ang_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            flash_q   <= flash_d;
            err_q     <= err_d;
            tmo_q     <= tmo_d;
        end
    end

    assign lidar_header = HEADER;
    assign data         = data_q;
    assign flashin      = flash_q;
    assign frame_err    = err_q;
    assign tx_timeout   = tmo_q;
    assign busy         = !(state_q == StHunt0 || state_q == StHunt1);

endmodule

// File: tb/tb_lidar_frame_processor.sv
// Self-checking bench for lidar_frame_processor with NUM_SAMPLES=4.
module tb_lidar_frame_processor;

    localparam int          NS  = 4;
    localparam logic [15:0] HDR = 16'h55AA;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_byte = 8'h00;
    logic        rx_valid = 1'b0;
    logic        tx_busy = 1'b0;
    logic [15:0] lidar_header;
    logic [47:0] data;
    logic        flashin;
    logic        frame_err;
    logic        tx_timeout;
    logic        busy;

    lidar_frame_processor #(
        .NUM_SAMPLES (NS),
        .ALERT_THRESH(16'd500),
        .FLASH_CYCLES(4),
        .BUSY_TIMEOUT(8),
        .HEADER      (HDR)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .rx_byte     (rx_byte),
        .rx_valid    (rx_valid),
        .tx_busy     (tx_busy),
        .lidar_header(lidar_header),
        .data        (data),
        .flashin     (flashin),
        .frame_err   (frame_err),
        .tx_timeout  (tx_timeout),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    int          checks = 0;
    int          errors = 0;
    int          err_pulses = 0;
    int          tmo_pulses = 0;
    logic [47:0] exp_data = 48'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference result: find extreme values first, then the first index holding each.
    function automatic logic [47:0] model_result(input logic [NS-1:0][15:0] s);
        logic [15:0] mx, mn;
        int          amax, amin;
        logic [31:0] a1, a2;
        mx = 16'h0000;
        mn = 16'hFFFF;
        for (int i = 0; i < NS; i++) begin
            if (s[i] > mx) mx = s[i];
            if (s[i] < mn) mn = s[i];
        end
        amax = -1;
        amin = -1;
        for (int i = 0; i < NS; i++) begin
            if (amax < 0 && s[i] == mx) amax = i;
            if (amin < 0 && s[i] == mn) amin = i;
        end
        a1 = 32'(amax);
        a2 = 32'(amin);
        return {a1[15:0], a2[15:0], 15'd0, (mn < 16'd500)};
    endfunction

    function automatic logic [7:0] model_chk(input logic [NS-1:0][15:0] s);
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < NS; i++) x = x ^ s[i][15:8] ^ s[i][7:0];
        return x;
    endfunction

    // Per-cycle compare of the result bus and header against the model.
    always @(negedge clock) begin
        check("data_vs_model", 64'(data), 64'(exp_data));
        check("lidar_header", 64'(lidar_header), 64'(HDR));
        if (frame_err)  err_pulses++;
        if (tx_timeout) tmo_pulses++;
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(posedge clock);
        #1;
        rx_valid = 1'b0;
    endtask

    // Samples and checksum (optionally corrupted); gap idles between bytes.
    task automatic send_body(input logic [NS-1:0][15:0] s, input logic [7:0] chk_xor,
                             input int gap);
        for (int i = 0; i < NS; i++) begin
            send_byte(s[i][15:8]);
            idle(gap);
            send_byte(s[i][7:0]);
            idle(gap);
        end
        send_byte(model_chk(s) ^ chk_xor);
    endtask

    task automatic wait_flash_rise(output int lat);
        lat = 0;
        while (!flashin && lat < 64) begin
            idle(1);
            lat++;
        end
    endtask

    task automatic count_flash(output int n);
        n = 0;
        while (flashin && n < 64) begin
            n++;
            idle(1);
        end
    endtask

    // Transmitter model: busy one cycle after flashin falls, held 66 cycles.
    task automatic respond_tx(input string tag);
        idle(1);
        tx_busy = 1'b1;
        idle(66);
        check({tag, "_busy_in_tx"}, 64'(busy), 64'(1));
        tx_busy = 1'b0;
        idle(1);
        check({tag, "_busy_after_tx"}, 64'(busy), 64'(0));
    endtask

    task automatic launch_and_respond(input string tag);
        int lat, n;
        wait_flash_rise(lat);
        check({tag, "_flash_latency"}, 64'(lat), 64'(1));
        count_flash(n);
        check({tag, "_flash_cycles"}, 64'(n), 64'(4));
        respond_tx(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [NS-1:0][15:0] s1, s3, s4;
        int lat, n, k;
        s1 = {16'h0300, 16'h0050, 16'h0300, 16'h0100};
        s3 = {16'h0010, 16'h0900, 16'h0010, 16'h0200};
        s4 = {4{16'h0400}};

        // Reset values
        idle(2);
        check("rst_flashin", 64'(flashin), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_frame_err", 64'(frame_err), 64'(0));
        check("rst_tx_timeout", 64'(tx_timeout), 64'(0));
        check("rst_data", 64'(data), 64'(0));
        reset = 1'b0;
        idle(1);

        // Pin the model with hand-computed values
        check("model_s1", 64'(model_result(s1)), 64'h0001_0002_0001);
        check("chk_s1", 64'(model_chk(s1)), 64'h51);
        check("model_s3", 64'(model_result(s3)), 64'h0002_0001_0001);
        check("chk_s3", 64'(model_chk(s3)), 64'h0B);
        check("model_s4", 64'(model_result(s4)), 64'h0);
        check("chk_s4", 64'(model_chk(s4)), 64'h00);

        // Good frame
        send_byte(8'h55);
        send_byte(8'hAA);
        send_body(s1, 8'h00, 0);
        exp_data = model_result(s1);
        check("t1_data", 64'(data), 64'h0001_0002_0001);
        check("t1_frame_err", 64'(frame_err), 64'(0));
        check("t1_busy", 64'(busy), 64'(1));
        launch_and_respond("t1");

        // Bad checksum 0x52
        send_byte(8'h55);
        send_byte(8'hAA);
        send_body(s1, 8'h03, 0);
        check("t2_frame_err", 64'(frame_err), 64'(1));
        check("t2_busy", 64'(busy), 64'(0));
        idle(1);
        check("t2_frame_err_pulse", 64'(frame_err), 64'(0));
        for (int i = 0; i < 5; i++) begin
            check("t2_no_flash", 64'(flashin), 64'(0));
            idle(1);
        end
        check("t2_err_pulses", 64'(err_pulses), 64'(1));

        // Resync on repeated first header byte, gapped byte stream
        send_byte(8'h55);
        send_byte(8'h55);
        send_byte(8'hAA);
        send_body(s3, 8'h00, 1);
        exp_data = model_result(s3);
        launch_and_respond("t3");

        // Broken header must not lock on
        send_byte(8'h55);
        send_byte(8'h12);
        send_byte(8'hAA);
        send_body(s1, 8'h00, 0);
        idle(1);
        check("t4_not_accepted_busy", 64'(busy), 64'(0));
        check("t4_not_accepted_flash", 64'(flashin), 64'(0));

        // Fresh header, equal samples, transmitter busy at launch, then timeout
        tx_busy = 1'b1;
        send_byte(8'h55);
        send_byte(8'hAA);
        send_body(s4, 8'h00, 0);
        exp_data = model_result(s4);
        for (int i = 0; i < 10; i++) begin
            check("t5_hold_flash", 64'(flashin), 64'(0));
            check("t5_hold_busy", 64'(busy), 64'(1));
            idle(1);
        end
        tx_busy = 1'b0;
        wait_flash_rise(lat);
        check("t5_flash_after_release", 64'(lat), 64'(1));
        count_flash(n);
        check("t5_flash_cycles", 64'(n), 64'(4));
        k = 0;
        while (!tx_timeout && k < 20) begin
            idle(1);
            k++;
        end
        check("t5_timeout_cycles", 64'(k), 64'(8));
        check("t5_busy_after_timeout", 64'(busy), 64'(0));
        idle(1);
        check("t5_timeout_pulse", 64'(tx_timeout), 64'(0));
        check("t5_tmo_pulses", 64'(tmo_pulses), 64'(1));

        // Good frame again so the result bus is nonzero
        send_byte(8'h55);
        send_byte(8'hAA);
        send_body(s1, 8'h00, 0);
        exp_data = model_result(s1);
        launch_and_respond("t6");

        // Reset after 5 sample bytes
        send_byte(8'h55);
        send_byte(8'hAA);
        send_byte(s3[0][15:8]);
        send_byte(s3[0][7:0]);
        send_byte(s3[1][15:8]);
        send_byte(s3[1][7:0]);
        send_byte(s3[2][15:8]);
        reset = 1'b1;
        idle(1);
        exp_data = 48'd0;
        check("t7_flashin", 64'(flashin), 64'(0));
        check("t7_busy", 64'(busy), 64'(0));
        check("t7_data", 64'(data), 64'(0));
        reset = 1'b0;
        idle(1);

        // Full frame after reset
        send_byte(8'h55);
        send_byte(8'hAA);
        send_body(s3, 8'h00, 0);
        exp_data = model_result(s3);
        check("t8_data", 64'(data), 64'h0002_0001_0001);
        launch_and_respond("t8");
        check("final_err_pulses", 64'(err_pulses), 64'(1));
        check("final_tmo_pulses", 64'(tmo_pulses), 64'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lidar_frame_processor.md
Name: lidar_frame_processor

Overview:
- Upstream neighbour of the UART transmit stage.
- Consumes the byte stream from the UART receiver: a LiDAR frame consisting of header 0x55 0xAA, NUM_SAMPLES 16-bit distance samples and an XOR checksum.
- Computes max-distance angle, min-distance angle and an obstacle alert.
- Presents the 48-bit result plus header to the transmitter and drives its flashin/tx_busy handshake.

Parameters:
- NUM_SAMPLES, 8: distance samples per frame; angle = sample index 0..NUM_SAMPLES-1; legal range 2..256.
- ALERT_THRESH, 16'd500: obstacle alert asserted when min distance < ALERT_THRESH (unsigned).
- FLASH_CYCLES, 4: cycles flashin is held high per launch; must be ≥2.
- BUSY_TIMEOUT, 8: cycles to wait for tx_busy rise after flashin falls.
- HEADER, 16'h55AA: frame header; first byte is HEADER[15:8].

Ports:
- clock, in, 1: single clock; all logic on rising edge.
- reset, in, 1: synchronous, active-high.
- rx_byte, in, 8: received byte.
- rx_valid, in, 1: one-cycle strobe; rx_byte is valid when high.
- tx_busy, in, 1: transmitter busy.
- lidar_header, out, 16: constant HEADER.
- data, out, 48: {max_angle[15:0], min_angle[15:0], obs_alert[15:0]}.
- flashin, out, 1: transmit enable to the transmitter.
- frame_err, out, 1: one-cycle pulse on checksum mismatch.
- tx_timeout, out, 1: one-cycle pulse when tx_busy never rises.
- busy, out, 1: high in any state other than HUNT0/HUNT1.

Behaviour:
- Reset (synchronous):
  - Registered outputs: data=0, flashin=0, frame_err=0, tx_timeout=0.
  - State=HUNT0; sample index, checksum, max/min registers cleared.
  - busy is combinational from state, so it reads 0 during reset.
  - Reset overrides any in-progress frame or launch.
- Byte acceptance: rx_byte is examined only on cycles with rx_valid=1.
- States:
  - HUNT0: byte==HEADER[15:8] → HUNT1; else stay.
  - HUNT1: byte==HEADER[7:0] → SAMP_HI, clear index/checksum, init max=0 and min=16'hFFFF; byte==HEADER[15:8] → stay in HUNT1 (resync); otherwise → HUNT0.
  - SAMP_HI: latch high byte, chk ^= byte → SAMP_LO.
  - SAMP_LO:
    - sample = {hi, byte}; chk ^= byte.
    - If sample > max (strict): update max and max_angle. If sample < min (strict): update min and min_angle. Ties keep the lowest index.
    - If index == NUM_SAMPLES-1 → CHECK; else index+1 → SAMP_HI.
  - CHECK (on the next valid byte):
    - byte == chk → latch data = {max_angle, min_angle, (min<ALERT_THRESH)?16'h0001:16'h0000}, then → LAUNCH.
    - Mismatch → frame_err pulses 1 cycle, data unchanged, → HUNT0.
  - LAUNCH:
    - Wait until tx_busy==0.
    - Then flashin=1 for exactly FLASH_CYCLES consecutive cycles, then flashin=0 → WAIT_BUSY.
    - data stays stable from entry to LAUNCH until the next successful CHECK.
  - WAIT_BUSY:
    - tx_busy==1 → WAIT_DONE.
    - After BUSY_TIMEOUT cycles without the rise, tx_timeout pulses 1 cycle → HUNT0.
  - WAIT_DONE: tx_busy==0 → HUNT0.
- Header bytes inside samples are not treated as resync; only the checksum rejects corrupted frames.
- rx_valid during CHECK..WAIT_DONE: the CHECK byte is consumed; bytes arriving in LAUNCH/WAIT_BUSY/WAIT_DONE are dropped (no buffering). Frames overlapping a transmission are lost, and the next frame is found by hunting.
- Checksum: XOR of all 2*NUM_SAMPLES sample bytes; header bytes are excluded.
- Latency: the data update occurs on the clock edge after the checksum byte is accepted. flashin rises one cycle after LAUNCH is entered, provided tx_busy is low.

Test Plan:
- NUM_SAMPLES=4; bytes 55 AA 01 00 03 00 00 50 03 00 51 → data=48'h0001_0002_0001, flashin high 4 cycles, no frame_err.
- Same frame with checksum 52 → frame_err pulses once, flashin stays 0, data unchanged, state returns to HUNT0.
- Resync: bytes 55 55 AA followed by a valid frame body → frame accepted. Bytes 55 12 AA ... → not accepted until a fresh 55 AA.
- Samples all 0x0400, checksum 00 → max_angle=0, min_angle=0 (ties keep lowest index), alert=0 (1024 ≥ 500).
- tx_busy held 1 when LAUNCH is entered, released 10 cycles later → flashin rises on the cycle after the release. Bench model raises tx_busy 1 cycle after flashin falls and drops it 66 cycles later → return to HUNT0. With tx_busy never rising → tx_timeout pulse after 8 cycles.
- Assert reset mid-sample (after 5 sample bytes) → next cycle flashin=0, busy=0, data=0. A subsequent full frame is processed correctly.
